hdc_ngram_encoder: RTL and testbench
====================================

Name: hdc_ngram_encoder

Overview:
Parametrised successor to the single-rotation HDC encoder core. Holds an item memory of hypervectors and accepts a stream of symbol indices. It binds each non-overlapping n-gram (runtime length) by XOR of rotated item vectors, then bundles all n-grams with per-bit saturating counters. On end of sequence it emits the majority hypervector over a valid/ready handshake. Sits between the host symbol DMA and the similarity/classifier stage.

Parameters:
DIM, 1024, hypervector width in bits
ADDR_W, 10, item-memory address width; depth is 2**ADDR_W
NGRAM_MAX, 8, maximum n-gram length; rotation amounts are 0..NGRAM_MAX-1
CNT_W, 8, width of each per-bit bundle counter and of the n-gram count

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; honoured only in IDLE; clears counters and latches n_len
n_len  in  $clog2(NGRAM_MAX+1)  n-gram length; 0 is treated as 1, values above NGRAM_MAX clamp to NGRAM_MAX
wr_en  in  1  item-memory write strobe; honoured only in IDLE
wr_addr  in  ADDR_W  item-memory write address
wr_data  in  DIM  item hypervector
s_valid  in  1  symbol valid
s_ready  out  1  symbol ready
s_sym  in  ADDR_W  symbol index, used as the item-memory address
s_last  in  1  last symbol of the sequence
m_valid  out  1  result valid
m_ready  in  1  result ready
m_hv  out  DIM  bundled majority hypervector
m_count  out  CNT_W  number of n-grams bundled, saturating
overflow  out  1  sticky flag; set when any counter saturates; cleared by start
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, rst_n=0) values: state IDLE, s_ready=0, m_valid=0, m_hv=0, m_count=0, overflow=0, busy=0, all counters and the accumulator 0. Item-memory contents are not reset.
- Reset asserted mid-operation aborts immediately; nothing is emitted.
- Item memory is single-port block RAM with 1-cycle read latency. Writes occur only in IDLE, so there is no read/write collision.
- States and transitions:
  - IDLE: start moves to ACCEPT.
  - ACCEPT: s_ready=1; a handshake issues the RAM read, latches s_last, and moves to BIND.
  - BIND: s_ready=0; acc <= acc ^ rotr(item, pos).
    - If pos == n_len-1: next is BUNDLE.
    - Else if last: next is OUT.
    - Else: pos++ and next is ACCEPT.
  - BUNDLE: for each bit i with acc[i]=1, cnt[i]++ (saturating); total++ (saturating); acc<=0; pos<=0. Next is OUT if last, else ACCEPT.
  - OUT: m_valid=1; m_hv[i] = (2*cnt[i] > total); m_count=total. Outputs are held stable until m_ready; on handshake go to IDLE.
- Throughput: 2 cycles per symbol, plus 1 cycle per completed n-gram.
- rotr(v,k) = {v[k-1:0], v[DIM-1:k]}; k=0 is the identity. The symbol at window position k is rotated right by k.
- Partial n-gram at s_last is discarded, not bundled.
- Empty result: total=0 gives m_hv=0 and m_count=0.
- Ties (2*cnt == total) resolve to 0.
- Counter saturation: any cnt[i] or total reaching 2**CNT_W-1 holds at that value and sets overflow.
- The majority compare uses CNT_W+1 bits; there is no wrap.
- start outside IDLE is ignored. wr_en outside IDLE is ignored.

Decomposition:
- Package hdc_pkg holds:
  - the state enum: IDLE, ACCEPT, BIND, BUNDLE, OUT;
  - a function rotr(v, k) implemented as a barrel mux over 0..NGRAM_MAX-1;
  - a majority-threshold function;
  - default DIM/ADDR_W/CNT_W localparams.
- One sub-module is natural: hdc_bundle_counters (DIM saturating counters plus total, clear/inc/saturation flag, majority output).

Test Plan:
- DIM=16; item[1]=16'h0001, item[2]=16'h8000; n_len=2; symbols 1,2 (last on 2) -> m_hv=16'h4001, m_count=1, overflow=0.
- n_len=1; symbols 1,1,2 -> counts bit0=2, bit15=1, total=3 -> m_hv=16'h0001, m_count=3.
- Tie case: n_len=1; symbols 1,2 -> m_hv=16'h0000, m_count=2.
- Partial discard: n_len=3; symbols 1,2,1,2 (last) -> one n-gram 0001^4000^4000 -> m_hv=16'h0001, m_count=1.
- Saturation: CNT_W=3, n_len=1, eight symbols 1 -> m_count=7, overflow=1, m_hv=16'h0001; next start clears overflow.
- Backpressure and reset:
  - m_ready held low 5 cycles -> m_valid=1 with m_hv stable, s_ready=0; on handshake busy drops next cycle.
  - rst_n pulsed during BIND -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/hdc_ngram_encoder_pkg.sv
// Shared types and helpers for the n-gram hypervector encoder.
package hdc_pkg;

    localparam int unsigned DEF_DIM       = 1024;
    localparam int unsigned DEF_ADDR_W    = 10;
    localparam int unsigned DEF_NGRAM_MAX = 8;
    localparam int unsigned DEF_CNT_W     = 8;

    // Helpers operate on the widest supported vector/counter and are narrowed by callers.
    localparam int unsigned HV_MAX_W  = 1024;
    localparam int unsigned HV_IDX_W  = $clog2(HV_MAX_W);
    localparam int unsigned CNT_MAX_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        BIND,
        BUNDLE,
        OUT
    } state_e;

    typedef logic [HV_MAX_W-1:0]  hv_max_t;
    typedef logic [CNT_MAX_W-1:0] cnt_max_t;

    // Rotate the low `dim` bits of v right by k, k in 0..DEF_NGRAM_MAX-1.
    function automatic hv_max_t rotr(input hv_max_t v, input int unsigned dim,
                                     input int unsigned k);
        hv_max_t r;
        r = '0;
        for (int unsigned s = 0; s < DEF_NGRAM_MAX; s++) begin
            if (k == s) begin
                for (int unsigned i = 0; i < dim; i++) begin
                    r[HV_IDX_W'(i)] = v[HV_IDX_W'((i + s) % dim)];
                end
            end
        end
        return r;
    endfunction

    // Strict majority: 2*cnt > total, one extra bit so the doubling cannot wrap.
    function automatic logic majority(input cnt_max_t cnt, input cnt_max_t total);
        return {cnt, 1'b0} > {1'b0, total};
    endfunction

endpackage

// File: rtl/hdc_ngram_encoder_if.sv
// Symbol-in / hypervector-out handshake bundle of the n-gram encoder.
interface hdc_ngram_encoder_if
    import hdc_pkg::*;
#(
    parameter int unsigned DIM    = DEF_DIM,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
);
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] s_sym;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DIM-1:0]    m_hv;
    logic [CNT_W-1:0]  m_count;

    modport master (
        output s_valid, s_sym, s_last, m_ready,
        input  s_ready, m_valid, m_hv, m_count
    );

    modport slave (
        input  s_valid, s_sym, s_last, m_ready,
        output s_ready, m_valid, m_hv, m_count
    );
endinterface

// File: rtl/hdc_bundle_counters.sv
// Per-bit saturating bundle counters plus n-gram total, with registered majority vector.
module hdc_bundle_counters
    import hdc_pkg::*;
#(
    parameter int unsigned DIM   = DEF_DIM,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [DIM-1:0]   bits,
    output logic [DIM-1:0]   maj_hv,
    output logic [CNT_W-1:0] total,
    output logic             sat_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [DIM];
    logic [CNT_W-1:0] cnt_d [DIM];
    logic [CNT_W-1:0] total_d;
    logic [DIM-1:0]   maj_d;

    // Majority is taken on the next-state counts so it is ready in the same cycle they land.
    always_comb begin
        total_d = total;
        sat_c   = 1'b0;
        maj_d   = '0;
        if (clr) begin
            total_d = '0;
        end else if (inc) begin
            if (total != CNT_MAX) total_d = total + CNT_W'(1);
            if (total_d == CNT_MAX) sat_c = 1'b1;
        end
        for (int unsigned i = 0; i < DIM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (inc && bits[i]) begin
                if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                if (cnt_d[i] == CNT_MAX) sat_c = 1'b1;
            end
            maj_d[i] = majority(CNT_MAX_W'(cnt_d[i]), CNT_MAX_W'(total_d));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total  <= '0;
            maj_hv <= '0;
            for (int unsigned i = 0; i < DIM; i++) cnt_q[i] <= '0;
        end else begin
            total  <= total_d;
            maj_hv <= maj_d;
            for (int unsigned i = 0; i < DIM; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: rtl/hdc_ngram_encoder.sv
// N-gram HDC encoder: binds rotated item vectors per window, bundles windows, emits majority.
module hdc_ngram_encoder
    import hdc_pkg::*;
#(
    parameter int unsigned DIM       = DEF_DIM,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned NGRAM_MAX = DEF_NGRAM_MAX,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [$clog2(NGRAM_MAX+1)-1:0]   n_len,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DIM-1:0]                   wr_data,
    hdc_ngram_encoder_if.slave               bus,
    output logic                             overflow,
    output logic                             busy
);

    localparam int unsigned      LEN_W   = $clog2(NGRAM_MAX + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NGRAM_MAX);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   pos_q, nlen_q, nlen_c;
    logic               last_q;
    logic [DIM-1:0]     acc_q, rd_data, rot_c;
    logic [DIM-1:0]     mem [2**ADDR_W];
    logic               s_ready_q, m_valid_q;
    logic [DIM-1:0]     hv_q;
    logic [CNT_W-1:0]   total_q;
    logic               sat_c;
    logic               clr_c, rd_en_c, bind_c, bundle_c;

    always_comb begin
        state_d  = state_q;
        clr_c    = 1'b0;
        rd_en_c  = 1'b0;
        bind_c   = 1'b0;
        bundle_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr_c   = 1'b1;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (bus.s_valid) begin
                    rd_en_c = 1'b1;
                    state_d = BIND;
                end
            end
            BIND: begin
                bind_c = 1'b1;
                if (pos_q == nlen_q - LEN_W'(1)) state_d = BUNDLE;
                else if (last_q)                 state_d = OUT;
                else                             state_d = ACCEPT;
            end
            BUNDLE: begin
                bundle_c = 1'b1;
                state_d  = last_q ? OUT : ACCEPT;
            end
            OUT: begin
                if (bus.m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign nlen_c = (n_len == '0) ? LEN_W'(1) : ((n_len > LEN_MAX) ? LEN_MAX : n_len);
    assign rot_c  = DIM'(rotr(HV_MAX_W'(rd_data), DIM, 32'(pos_q)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            nlen_q    <= LEN_W'(1);
            last_q    <= 1'b0;
            acc_q     <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d == ACCEPT);
            m_valid_q <= (state_d == OUT);
            busy      <= (state_d != IDLE);
            if (clr_c) begin
                nlen_q   <= nlen_c;
                pos_q    <= '0;
                acc_q    <= '0;
                overflow <= 1'b0;
            end
            if (rd_en_c) last_q <= bus.s_last;
            if (bind_c) begin
                acc_q <= acc_q ^ rot_c;
                if (state_d == ACCEPT) pos_q <= pos_q + LEN_W'(1);
            end
            if (bundle_c) begin
                acc_q <= '0;
                pos_q <= '0;
                if (sat_c) overflow <= 1'b1;
            end
        end
    end

    // Item memory: block RAM, writes only while idle, 1-cycle registered read.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && wr_en) mem[wr_addr] <= wr_data;
        if (rd_en_c) rd_data <= mem[bus.s_sym];
    end

    hdc_bundle_counters #(
        .DIM   (DIM),
        .CNT_W (CNT_W)
    ) u_counters (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr_c),
        .inc    (bundle_c),
        .bits   (acc_q),
        .maj_hv (hv_q),
        .total  (total_q),
        .sat_c  (sat_c)
    );

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_hv    = hv_q;
    assign bus.m_count = total_q;

endmodule

// File: tb/tb_hdc_ngram_encoder.sv
// Directed scoreboard bench for hdc_ngram_encoder at DIM=16, CNT_W=3.
module tb_hdc_ngram_encoder;

    localparam int unsigned DIM       = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned NGRAM_MAX = 8;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned LEN_W     = $clog2(NGRAM_MAX + 1);
    localparam int          CMAX      = (1 << CNT_W) - 1;

    typedef struct {
        logic [DIM-1:0]   hv;
        logic [CNT_W-1:0] count;
        logic             ovf;
    } exp_t;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  n_len = '0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DIM-1:0]    wr_data = '0;
    logic              overflow;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [DIM-1:0] items [2**ADDR_W];
    int             seq_q [$];
    exp_t           exp_q [$];

    hdc_ngram_encoder_if #(.DIM(DIM), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    hdc_ngram_encoder #(
        .DIM(DIM), .ADDR_W(ADDR_W), .NGRAM_MAX(NGRAM_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .n_len    (n_len),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .bus      (bus),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [DIM-1:0] m_rot(input logic [DIM-1:0] v, input int k);
        logic [2*DIM-1:0] d;
        d = {v, v} >> k;
        return d[DIM-1:0];
    endfunction

    // Model the expected result of seq_q, push it, then drive it and compare the output.
    task automatic run_seq(input int nl, input int hold, input bit glitch);
        exp_t           e, got;
        int             eff, pos, total, wait_n;
        int             cnt [DIM];
        logic [DIM-1:0] acc;
        eff   = (nl == 0) ? 1 : ((nl > int'(NGRAM_MAX)) ? int'(NGRAM_MAX) : nl);
        pos   = 0;
        total = 0;
        acc   = '0;
        e.ovf = 1'b0;
        for (int b = 0; b < int'(DIM); b++) cnt[b] = 0;
        for (int j = 0; j < seq_q.size(); j++) begin
            acc = acc ^ m_rot(items[seq_q[j]], pos);
            if (pos == eff - 1) begin
                for (int b = 0; b < int'(DIM); b++) begin
                    if (acc[b]) begin
                        if (cnt[b] < CMAX) cnt[b]++;
                        if (cnt[b] == CMAX) e.ovf = 1'b1;
                    end
                end
                if (total < CMAX) total++;
                if (total == CMAX) e.ovf = 1'b1;
                acc = '0;
                pos = 0;
            end else begin
                pos++;
            end
        end
        for (int b = 0; b < int'(DIM); b++) e.hv[b] = (2 * cnt[b] > total);
        e.count = CNT_W'(total);
        exp_q.push_back(e);

        @(negedge clk);
        n_len = LEN_W'(nl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clears_overflow", 32'(overflow), 32'(0));
        if (glitch) begin
            start   = 1'b1;
            n_len   = LEN_W'(1);
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(1);
            wr_data = '1;
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
        end
        for (int j = 0; j < seq_q.size(); j++) begin
            bus.s_valid = 1'b1;
            bus.s_sym   = ADDR_W'(seq_q[j]);
            bus.s_last  = (j == seq_q.size() - 1);
            wait_n = 0;
            while (!bus.s_ready && wait_n < 20) begin
                @(negedge clk);
                wait_n++;
            end
            chk("s_ready_wait", 32'(bus.s_ready), 32'(1));
            @(posedge clk);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        wait_n = 0;
        while (!bus.m_valid && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        chk("m_valid_wait", 32'(bus.m_valid), 32'(1));
        got = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            chk("bp_m_valid", 32'(bus.m_valid), 32'(1));
            chk("bp_m_hv", 32'(bus.m_hv), 32'(got.hv));
            chk("bp_s_ready", 32'(bus.s_ready), 32'(0));
            @(negedge clk);
        end
        chk("m_hv", 32'(bus.m_hv), 32'(got.hv));
        chk("m_count", 32'(bus.m_count), 32'(got.count));
        chk("overflow", 32'(overflow), 32'(got.ovf));
        bus.m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.m_ready = 1'b0;
        chk("busy_after_hs", 32'(busy), 32'(0));
        chk("m_valid_after_hs", 32'(bus.m_valid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int addrs [4];
        logic [DIM-1:0] vals [4];
        bus.s_valid = 1'b0;
        bus.s_sym   = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s_ready", 32'(bus.s_ready), 32'(0));
        chk("rst_m_valid", 32'(bus.m_valid), 32'(0));
        chk("rst_m_hv", 32'(bus.m_hv), 32'(0));
        chk("rst_m_count", 32'(bus.m_count), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        addrs = '{1, 2, 3, 4};
        vals  = '{16'h0001, 16'h8000, 16'h00F0, 16'h1234};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(addrs[i]);
            wr_data = vals[i];
            items[addrs[i]] = vals[i];
        end
        @(negedge clk);
        wr_en = 1'b0;

        seq_q = '{1, 2};                   run_seq(2, 0, 1'b0);
        seq_q = '{1, 1, 2};                run_seq(1, 0, 1'b0);
        seq_q = '{1, 2};                   run_seq(1, 0, 1'b0);
        seq_q = '{1, 2, 1, 2};             run_seq(3, 0, 1'b0);
        seq_q = '{1, 2};                   run_seq(0, 0, 1'b0);
        seq_q = '{3, 4, 1, 2, 3, 4, 1, 2}; run_seq(15, 0, 1'b0);
        seq_q = '{1};                      run_seq(2, 0, 1'b0);
        seq_q = '{1, 2};                   run_seq(2, 0, 1'b1);
        seq_q = '{1, 1, 1, 1, 1, 1, 1, 1}; run_seq(1, 5, 1'b0);

        // Abort in BIND after one n-gram has been bundled.
        @(negedge clk);
        n_len = LEN_W'(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_clears_overflow", 32'(overflow), 32'(0));
        bus.s_valid = 1'b1;
        bus.s_sym   = ADDR_W'(1);
        chk("abort_s_ready", 32'(bus.s_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_s_ready2", 32'(bus.s_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        chk("abort_pre_count", 32'(bus.m_count), 32'(1));
        chk("abort_pre_hv", 32'(bus.m_hv), 32'(16'h0001));
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        chk("abort_s_ready_rst", 32'(bus.s_ready), 32'(0));
        chk("abort_m_valid", 32'(bus.m_valid), 32'(0));
        chk("abort_m_hv", 32'(bus.m_hv), 32'(0));
        chk("abort_m_count", 32'(bus.m_count), 32'(0));
        chk("abort_overflow", 32'(overflow), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_m_valid", 32'(bus.m_valid), 32'(0));

        seq_q = '{1, 2};                   run_seq(2, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
